// File: rtl/dac_spi_tx.sv
// dac_spi_tx : serialises 8-bit DDS samples into 16-bit SPI frames for a
// 10-bit DAC at a fixed sample rate set by a free-running timer.
//
// Parameters
//   CLK_DIV    : sys_clk cycles per dac_sclk half-period (2..255)
//   SAMPLE_DIV : sys_clk cycles between conversion requests
//                (must be >= 35*CLK_DIV+1 for every request to be served)
//
// Ports
//   sys_clk    : single clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   dac_data   : unsigned sample, captured only on a conversion start
//   dac_sclk   : serial DAC clock (idle low, data sampled on rising edge)
//   dac_cs_n   : active-low DAC chip select
//   dac_din    : serial data, MSB first
//   frame_done : one-cycle pulse in the last cycle of each frame
//   overrun    : one-cycle pulse when a request tick arrives mid-frame
//
// Frame layout: {4'b0000, sample[7:0], 4'b0000}
//   = 4 dummy bits, 10-bit DAC code (sample followed by 2'b00), 2 sub-LSB zeros.
//
// Optional feature (macro DAC_SPI_SIGNED_EN): bit 7 of dac_data is inverted at
// capture, converting a two's complement sample to offset binary.
//
// Every output is a flop. The output flops are loaded from a decode of the
// *next* FSM state, so each registered output lines up with the cycle its
// state is active without any combinational path to the pins.

module dac_spi_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SAMPLE_DIV = 200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] dac_data,
  output logic       dac_sclk,
  output logic       dac_cs_n,
  output logic       dac_din,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned     TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [4:0]    half_q, half_d;
  logic [15:0]   frame_q, frame_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          din_q, din_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic          tick_next;
  logic          div_last;
  logic [7:0]    sample;
  logic [3:0]    bit_idx;

  // Sample presented to the frame at capture time.
  always_comb begin
    sample = dac_data;
`ifdef DAC_SPI_SIGNED_EN
    sample[7] = ~dac_data[7];
`endif
  end

  // Free-running request timer. tick_next predicts the tick of the following
  // cycle so that the registered overrun pulse coincides with the tick itself.
  always_comb begin
    tick      = (timer_q == TIMER_LAST);
    timer_d   = tick ? '0 : timer_q + TW'(1);
    tick_next = (timer_d == TIMER_LAST);
  end

  // Next-state logic. Every phase lasts a whole number of CLK_DIV-cycle slots;
  // SHIFT additionally walks through 32 half-periods.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    half_d    = half_q;
    frame_d   = frame_q;
    div_last  = (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = CS_SETUP;
          div_cnt_d = '0;
          half_d    = '0;
          frame_d   = {4'b0000, sample, 4'b0000};
        end
      end
      CS_SETUP: begin
        if (div_last) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
          half_d    = '0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (half_q == 5'd31) begin
            state_d = CS_HOLD;
          end else begin
            half_d = half_q + 5'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      CS_HOLD: begin
        if (div_last) begin
          state_d   = CS_HIGH;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      CS_HIGH: begin
        if (div_last) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state. Data moves to the next lower bit on
  // each falling sclk (odd half-periods 1..29) and sits on bit 0 for the last
  // rising edge and the closing half-period, so the DAC samples bits 15..0
  // on the 16 rising edges.
  always_comb begin
    sclk_d    = 1'b0;
    cs_n_d    = 1'b1;
    din_d     = 1'b0;
    done_d    = 1'b0;
    overrun_d = tick_next && (state_d != IDLE);

    if (half_d >= 5'd29) begin
      bit_idx = 4'd0;
    end else begin
      bit_idx = 4'd15 - 4'((half_d + 5'd1) >> 1);
    end

    case (state_d)
      CS_SETUP: begin
        cs_n_d = 1'b0;
        din_d  = frame_d[15];
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = ~half_d[0];
        din_d  = frame_d[bit_idx];
      end
      CS_HOLD: begin
        cs_n_d = 1'b0;
      end
      CS_HIGH: begin
        done_d = (div_cnt_d == DIV_LAST);
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset parks the link idle with cs deasserted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      div_cnt_q <= '0;
      half_q    <= '0;
      frame_q   <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      din_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_cnt_q <= div_cnt_d;
      half_q    <= half_d;
      frame_q   <= frame_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      din_q     <= din_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_din    = din_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule
